hazard_ctrl: RTL and testbench

- Generates the stall/flush controls consumed by the ID/EX pipeline register (`hazard`, `BranchBubble`, `cp0bubble`), plus the PC and IF/ID hold and flush strobes.
- Sits beside the decode stage. Observes ID-stage operand usage and EX-stage control, and tracks an in-flight multiply/divide.
- Sequences multi-cycle stalls and flushes so that the pipeline registers only need to obey its outputs.

---
 rtl/pipe_pkg.sv | 21 ++
 rtl/hazard_ctrl_if.sv | 48 ++++
 rtl/mdu_busy_ctr.sv | 36 +++
 rtl/hazard_ctrl.sv | 100 ++++++++++
 tb/tb_hazard_ctrl.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline encodings: CP0 ops, writeback select, hazard FSM states and field widths.
package pipe_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned CNT_W = 6;
    localparam int unsigned BRC_W = 2;

    localparam logic [2:0] CP0_NOP     = 3'b000;
    localparam logic [2:0] CP0_ERET    = 3'b100;
    localparam logic [2:0] CP0_SYSCALL = 3'b101;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;

    typedef enum logic [1:0] {
        HZ_IDLE  = 2'd0,
        HZ_MDU   = 2'd1,
        HZ_FLUSH = 2'd2
    } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side observation and stall/flush control bundle for hazard_ctrl.
// Perf counter signals exist only when HAZARD_PERF_EN is defined.
interface hazard_ctrl_if;
    import pipe_pkg::*;

    logic [REG_W-1:0] id_ra;
    logic [REG_W-1:0] id_rb;
    logic             id_use_ra;
    logic             id_use_rb;
    logic             id_hl_read;
    logic             id_mdu_start;
    logic [REG_W-1:0] ex_rw;
    logic             ex_regWr;
    logic [1:0]       ex_memtoreg;
    logic             ex_br_taken;
    logic [2:0]       ex_cp0op;

    logic             pc_stall;
    logic             ifid_stall;
    logic             ifid_flush;
    logic             hazard;
    logic             BranchBubble;
    logic [1:0]       cp0bubble;
    logic             mdu_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0]      perf_stall_cnt;
    logic [31:0]      perf_flush_cnt;
`endif

    modport master (
        output id_ra, id_rb, id_use_ra, id_use_rb, id_hl_read, id_mdu_start,
        output ex_rw, ex_regWr, ex_memtoreg, ex_br_taken, ex_cp0op,
`ifdef HAZARD_PERF_EN
        input  perf_stall_cnt, perf_flush_cnt,
`endif
        input  pc_stall, ifid_stall, ifid_flush, hazard, BranchBubble, cp0bubble, mdu_busy
    );

    modport slave (
        input  id_ra, id_rb, id_use_ra, id_use_rb, id_hl_read, id_mdu_start,
        input  ex_rw, ex_regWr, ex_memtoreg, ex_br_taken, ex_cp0op,
`ifdef HAZARD_PERF_EN
        output perf_stall_cnt, perf_flush_cnt,
`endif
        output pc_stall, ifid_stall, ifid_flush, hazard, BranchBubble, cp0bubble, mdu_busy
    );

endinterface

// File: rtl/mdu_busy_ctr.sv
// Down counter tracking how long an issued mult/div still owns HI/LO.
module mdu_busy_ctr
    import pipe_pkg::*;
#(
    parameter int unsigned LAT = 32
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic busy,
    output logic last
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = CNT_W'(LAT - 1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign busy = (cnt_q != '0);
    assign last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / MDU stall and branch/CP0 bubble sequencing for the ID/EX boundary.
// Optional HAZARD_PERF_EN adds free-running stall and flush cycle counters.
module hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MDU_LAT  = 32,
    parameter int unsigned BR_FLUSH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    hazard_ctrl_if.slave hz
);

    hz_state_e        state_q, state_d;
    logic [BRC_W-1:0] br_cnt_q, br_cnt_d;
    logic             cp0_pend_q, cp0_pend_d;
    logic             load_use_c, mdu_stall_c, flush_c, stall_c, mdu_load_c;
    logic             mdu_busy, mdu_last;

    assign load_use_c = (hz.ex_memtoreg == WB_MEM) && hz.ex_regWr && (hz.ex_rw != '0) &&
                        ((hz.id_use_ra && (hz.id_ra == hz.ex_rw)) ||
                         (hz.id_use_rb && (hz.id_rb == hz.ex_rw)));
    assign mdu_stall_c = mdu_busy && (hz.id_hl_read || hz.id_mdu_start);

    // Flush dominates; rst_n gates the combinational paths so reset silences every output.
    assign flush_c    = rst_n && (hz.ex_br_taken || ((state_q == HZ_FLUSH) && (br_cnt_q != '0)));
    assign stall_c    = rst_n && !flush_c && (load_use_c || mdu_stall_c);
    assign mdu_load_c = hz.id_mdu_start && !stall_c && !flush_c;

    mdu_busy_ctr #(.LAT(MDU_LAT)) u_mdu (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (mdu_load_c),
        .busy  (mdu_busy),
        .last  (mdu_last)
    );

    always_comb begin
        state_d    = state_q;
        br_cnt_d   = br_cnt_q;
        cp0_pend_d = (hz.ex_cp0op == CP0_ERET) || (hz.ex_cp0op == CP0_SYSCALL);
        if (br_cnt_q != '0) begin
            br_cnt_d = br_cnt_q - BRC_W'(1);
        end
        case (state_q)
            HZ_IDLE:  if (mdu_load_c) state_d = HZ_MDU;
            HZ_MDU:   if (mdu_last) state_d = HZ_IDLE;
            HZ_FLUSH: if (br_cnt_q == '0) state_d = (mdu_busy && !mdu_last) ? HZ_MDU : HZ_IDLE;
            default:  state_d = HZ_IDLE;
        endcase
        // A taken branch always (re)starts the flush window; the MDU keeps counting underneath.
        if (hz.ex_br_taken) begin
            state_d  = HZ_FLUSH;
            br_cnt_d = BRC_W'(BR_FLUSH - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HZ_IDLE;
            br_cnt_q   <= '0;
            cp0_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            br_cnt_q   <= br_cnt_d;
            cp0_pend_q <= cp0_pend_d;
        end
    end

    assign hz.pc_stall     = stall_c;
    assign hz.ifid_stall   = stall_c;
    assign hz.hazard       = stall_c;
    assign hz.ifid_flush   = flush_c;
    assign hz.BranchBubble = flush_c;
    assign hz.cp0bubble    = {1'b0, cp0_pend_q};
    assign hz.mdu_busy     = mdu_busy;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d, perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + 32'(stall_c);
        perf_flush_d = perf_flush_q + 32'(flush_c);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign hz.perf_stall_cnt = perf_stall_q;
    assign hz.perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic against a cycle-count reference model.
module tb_hazard_ctrl;

    localparam int MDU_LAT  = 32;
    localparam int BR_FLUSH = 2;

    typedef struct packed {
        logic       rst_n;
        logic [4:0] id_ra;
        logic [4:0] id_rb;
        logic       use_ra;
        logic       use_rb;
        logic       hl_read;
        logic       mdu_start;
        logic [4:0] ex_rw;
        logic       ex_regwr;
        logic [1:0] memtoreg;
        logic       br;
        logic [2:0] cp0op;
    } stim_t;

    typedef struct packed {
        logic [7:0]  core;   // {pc_stall, ifid_stall, ifid_flush, hazard, BranchBubble, cp0bubble[1:0], mdu_busy}
        logic [31:0] pstall;
        logic [31:0] pflush;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    hazard_ctrl_if hz ();

    hazard_ctrl #(.MDU_LAT(MDU_LAT), .BR_FLUSH(BR_FLUSH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests = 0;
    int fails = 0;
    exp_t exp_q[$];

    // Reference model: absolute cycle numbers instead of counters.
    int cyc          = 0;
    int mdu_free_at  = 0;   // first cycle at which the MDU is no longer busy
    int flush_until  = -1;  // last cycle of the current flush window
    bit cp0_pend_m   = 1'b0;
    int unsigned n_stall = 0;
    int unsigned n_flush = 0;

    function automatic stim_t idle_stim();
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit busy, flush, lu, stall;
        @(negedge clk);
        rst_n             = s.rst_n;
        hz.id_ra          = s.id_ra;
        hz.id_rb          = s.id_rb;
        hz.id_use_ra      = s.use_ra;
        hz.id_use_rb      = s.use_rb;
        hz.id_hl_read     = s.hl_read;
        hz.id_mdu_start   = s.mdu_start;
        hz.ex_rw          = s.ex_rw;
        hz.ex_regWr       = s.ex_regwr;
        hz.ex_memtoreg    = s.memtoreg;
        hz.ex_br_taken    = s.br;
        hz.ex_cp0op       = s.cp0op;
        e = '0;
        e.cyc = cyc;
        if (!s.rst_n) begin
            mdu_free_at = 0;
            flush_until = -1;
            cp0_pend_m  = 1'b0;
            n_stall     = 0;
            n_flush     = 0;
        end else begin
            busy  = (cyc < mdu_free_at);
            flush = s.br || (cyc <= flush_until);
            lu    = (s.memtoreg == 2'd1) && s.ex_regwr && (s.ex_rw != 5'd0) &&
                    ((s.use_ra && s.id_ra == s.ex_rw) || (s.use_rb && s.id_rb == s.ex_rw));
            stall = !flush && (lu || (busy && (s.hl_read || s.mdu_start)));
            e.core = {stall, stall, flush, stall, flush, 1'b0, cp0_pend_m, busy};
            e.pstall = n_stall;
            e.pflush = n_flush;
            if (s.mdu_start && !stall && !flush) mdu_free_at = cyc + MDU_LAT;
            if (s.br) flush_until = cyc + BR_FLUSH - 1;
            cp0_pend_m = (s.cp0op == 3'b100) || (s.cp0op == 3'b101);
            if (stall) n_stall++;
            if (flush) n_flush++;
        end
        exp_q.push_back(e);
        cyc++;
    endtask

    // Monitor: pops one expectation per cycle, sampling mid low-phase.
    initial begin
        exp_t e;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.hazard,
                       hz.BranchBubble, hz.cp0bubble, hz.mdu_busy};
                tests++;
                if (got !== e.core) begin
                    fails++;
                    $display("FAIL outputs cyc=%0d got=%b required=%b (ps,is,if,hz,bb,cp0[2],busy)",
                             e.cyc, got, e.core);
                end
`ifdef HAZARD_PERF_EN
                if (rst_n) begin
                    tests++;
                    if (hz.perf_stall_cnt !== e.pstall || hz.perf_flush_cnt !== e.pflush) begin
                        fails++;
                        $display("FAIL perf cyc=%0d got stall=%0d flush=%0d required stall=%0d flush=%0d",
                                 e.cyc, hz.perf_stall_cnt, hz.perf_flush_cnt, e.pstall, e.pflush);
                    end
                end
`endif
            end
        end
    end

    initial begin
        stim_t s;
        rst_n = 1'b0;
        hz.id_ra = '0; hz.id_rb = '0; hz.id_use_ra = 0; hz.id_use_rb = 0;
        hz.id_hl_read = 0; hz.id_mdu_start = 0; hz.ex_rw = '0; hz.ex_regWr = 0;
        hz.ex_memtoreg = '0; hz.ex_br_taken = 0; hz.ex_cp0op = '0;

        // Reset
        s = idle_stim(); s.rst_n = 1'b0;
        repeat (3) step(s);
        step(idle_stim());

        // Load-use: lw r5 in EX, add r6,r5,r7 in ID; then load gone; then ex_rw=0
        s = idle_stim();
        s.ex_rw = 5'd5; s.ex_regwr = 1; s.memtoreg = 2'd1;
        s.id_ra = 5'd5; s.id_rb = 5'd7; s.use_ra = 1; s.use_rb = 1;
        step(s);
        s.memtoreg = 2'd0;
        step(s);
        s.memtoreg = 2'd1; s.ex_rw = 5'd0; s.id_ra = 5'd0;
        step(s);
        s = idle_stim();
        s.ex_rw = 5'd9; s.ex_regwr = 1; s.memtoreg = 2'd1; s.id_rb = 5'd9; s.use_rb = 1;
        step(s);

        // MDU: mult, then mflo held in ID until well after release
        s = idle_stim(); s.mdu_start = 1;
        step(s);
        s = idle_stim(); s.hl_read = 1;
        repeat (MDU_LAT + 2) step(s);

        // Branch flush with concurrent load-use, then a back-to-back reload
        s = idle_stim();
        s.br = 1; s.ex_rw = 5'd3; s.ex_regwr = 1; s.memtoreg = 2'd1; s.id_ra = 5'd3; s.use_ra = 1;
        step(s);
        s.br = 0;
        step(s);
        step(idle_stim());
        s = idle_stim(); s.br = 1;
        step(s);
        step(s);
        repeat (3) step(idle_stim());

        // Branch squashes an MDU start
        s = idle_stim(); s.br = 1; s.mdu_start = 1;
        step(s);
        repeat (3) step(idle_stim());

        // CP0 eret then syscall
        s = idle_stim(); s.cp0op = 3'b100;
        step(s);
        repeat (2) step(idle_stim());
        s = idle_stim(); s.cp0op = 3'b101;
        step(s);
        step(idle_stim());

        // Reset mid-MDU at count 10, with mflo sitting in ID
        s = idle_stim(); s.mdu_start = 1;
        step(s);
        s = idle_stim(); s.hl_read = 1;
        repeat (21) step(s);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if ({hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.hazard, hz.BranchBubble,
             hz.cp0bubble, hz.mdu_busy} !== 8'd0) begin
            fails++;
            $display("FAIL async_reset got=%b required=00000000",
                     {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.hazard, hz.BranchBubble,
                      hz.cp0bubble, hz.mdu_busy});
        end
        s = idle_stim(); s.rst_n = 1'b0; s.hl_read = 1;
        repeat (2) step(s);
        s.rst_n = 1'b1;
        repeat (3) step(s);

        // Random traffic over a small register range to provoke collisions
        for (int i = 0; i < 1500; i++) begin
            s = idle_stim();
            s.rst_n     = ($urandom_range(0, 299) != 0);
            s.id_ra     = 5'($urandom_range(0, 3));
            s.id_rb     = 5'($urandom_range(0, 3));
            s.use_ra    = 1'($urandom_range(0, 1));
            s.use_rb    = 1'($urandom_range(0, 1));
            s.hl_read   = ($urandom_range(0, 3) == 0);
            s.mdu_start = ($urandom_range(0, 11) == 0);
            s.ex_rw     = 5'($urandom_range(0, 3));
            s.ex_regwr  = 1'($urandom_range(0, 1));
            s.memtoreg  = 2'($urandom_range(0, 2));
            s.br        = ($urandom_range(0, 9) == 0);
            s.cp0op     = 3'($urandom_range(0, 7));
            step(s);
        end
        step(idle_stim());

        // Bounded drain of the scoreboard
        for (int k = 0; k < 5 && exp_q.size() > 0; k++) @(negedge clk);
        #5;
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
